// File: rtl/cpu_bus_if.sv
// cpu_bus_if
// Address/data bus between a 6502-style CPU (master) and a memory-side
// responder (slave).
//   a      : CPU address
//   rw_n   : 1 = read, 0 = write
//   d_in   : CPU write data
//   sync   : CPU opcode-fetch indicator
//   d_out  : responder read data (8'h00 when d_oe=0)
//   d_oe   : responder drives the data bus this cycle
//   rdy    : 1 = the access completes at this rising edge
//   sel    : the address decodes to the responder's region
// Handshake: the CPU holds a/rw_n/d_in/sync steady while rdy=0; an access
// completes at the first rising edge that sees rdy=1.
interface cpu_bus_if;
    logic [15:0] a;
    logic        rw_n;
    logic [7:0]  d_in;
    logic        sync;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        rdy;
    logic        sel;

    modport master (
        output a, rw_n, d_in, sync,
        input  d_out, d_oe, rdy, sel
    );

    modport slave (
        input  a, rw_n, d_in, sync,
        output d_out, d_oe, rdy, sel
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder on the CPU bus: a mirrored on-chip work RAM with
// programmable wait states signalled through rdy, plus an opcode-fetch counter.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous reset, active low
//   bus         : cpu_bus_if slave modport (a, rw_n, d_in, sync / d_out, d_oe, rdy, sel)
//   fetch_count : opcode fetches completed (sync & rdy edges), wraps
//   dbg_state   : current wait-state FSM state (0 IDLE, 1 WAIT, 2 ACK)
module cpu_mem_responder #(
    parameter int unsigned RAM_AW      = 11,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter logic [15:0] REGION_MASK = 16'h1FFF,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_bus_if.slave    bus,
    output logic [15:0] fetch_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [15:0]       addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [15:0]       fc_q, fc_d;

    logic [7:0]        mem [2**RAM_AW];
    logic [RAM_AW-1:0] idx;
    logic              sel;
    logic              rdy;
    logic              abort;
    logic              we;

    assign sel   = ((bus.a & ~REGION_MASK) == BASE);
    assign idx   = bus.a[RAM_AW-1:0];
    // The CPU must hold the same selected access for the whole wait sequence.
    assign abort = (bus.a != addr_q) || (bus.rw_n != rw_q) || !sel;

    always_comb begin
        rdy = 1'b1;
        if (WAIT_STATES != 0) begin
            case (state_q)
                S_IDLE:  rdy = !sel;
                S_WAIT:  rdy = 1'b0;
                // An access that changes during its final cycle is dropped,
                // so rdy stays low and no write can slip through.
                S_ACK:   rdy = !abort;
                default: rdy = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        if (WAIT_STATES != 0) begin
            case (state_q)
                S_IDLE: begin
                    if (sel) begin
                        addr_d = bus.a;
                        rw_d   = bus.rw_n;
                        if (WAIT_STATES == 1) begin
                            state_d = S_ACK;
                        end else begin
                            // The IDLE cycle is the first rdy-low cycle.
                            state_d = S_WAIT;
                            wcnt_d  = 4'(WAIT_STATES - 2);
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_d = S_IDLE;
                    end else if (wcnt_q == 4'd0) begin
                        state_d = S_ACK;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign fc_d = fc_q + {15'd0, bus.sync & rdy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b1;
            fc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            fc_q    <= fc_d;
        end
    end

    // RAM is not reset; gating with rst_n keeps an edge that coincides with
    // reset assertion from committing a write.
    assign we = sel && !bus.rw_n && rdy && rst_n;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= bus.d_in;
        end
    end

    assign bus.sel   = sel;
    assign bus.rdy   = rdy;
    assign bus.d_oe  = sel & bus.rw_n & rdy;
    assign bus.d_out = bus.d_oe ? mem[idx] : 8'h00;

    assign fetch_count = fc_q;
    assign dbg_state   = state_q;

endmodule
